// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its queue.
// Imported by fetch_queue and fetch_unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam logic [31:0] INST_BYTES = 32'd4;

    // Clears the byte offset so every fetch address is word aligned.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular buffer of fetched {pc, inst} pairs between the fetch stage and decode.
// Head is read combinationally; flush empties the queue in one cycle.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head_entry,
    output logic [CW-1:0] count,
    output logic         full,
    output logic         empty
);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] head_reg;
    logic [PW-1:0] head_next;
    logic [PW-1:0] tail_reg;
    logic [PW-1:0] tail_next;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Storage needs no reset: empty slots are never presented.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[tail_reg] <= push_entry;
        end
    end

    assign head_entry = mem[head_reg];

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (flush) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else begin
            if (do_push) begin
                tail_next = tail_reg + PW'(1);
            end
            if (do_pop) begin
                head_next = head_reg + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_next = count_reg + CW'(1);
                2'b01:   count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch requester: owns the PC and boot/run/halt FSM, issues one
// combinational-read fetch per cycle and hands queued entries to decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_rd_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic        halted
);

    localparam int CW = $clog2(QDEPTH) + 1;

    fetch_state_t  state_reg;
    fetch_state_t  state_next;
    logic [31:0]   pc_reg;
    logic [31:0]   pc_next;
    logic          fetch_fire;
    logic          pop;
    fetch_entry_t  push_entry;
    fetch_entry_t  head_entry;
    logic [CW-1:0] q_count;
    logic          q_full;
    logic          q_empty;

    // Next state, PC and fetch/dequeue strobes.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        fetch_fire = 1'b0;
        pop        = 1'b0;

        case (state_reg)
            S_BOOT: state_next = S_RUN;
            S_RUN: begin
                if (halt_req && !redirect_valid) begin
                    state_next = S_HALT;
                end
                fetch_fire = ~halt_req & ~redirect_valid & ~q_full;
            end
            S_HALT: begin
                if (redirect_valid) begin
                    state_next = S_RUN;
                end
            end
            default: state_next = S_BOOT;
        endcase

        // A redirect voids any handshake in the same cycle.
        pop = id_valid & id_ready & ~redirect_valid;

        if (redirect_valid) begin
            pc_next = align_word(redirect_pc);
        end else if (fetch_fire) begin
            pc_next = pc_reg + INST_BYTES;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_BOOT;
            pc_reg    <= RESET_PC;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

    assign push_entry = '{pc: pc_reg, inst: imem_inst};

    fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (fetch_fire),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .head_entry (head_entry),
        .count      (q_count),
        .full       (q_full),
        .empty      (q_empty)
    );

    assign imem_rd_en = fetch_fire;
    assign imem_addr  = fetch_fire ? pc_reg : 32'h0;
    assign id_valid   = (q_count != '0);
    assign id_inst    = q_empty ? 32'h0 : head_entry.inst;
    assign id_pc      = q_empty ? 32'h0 : head_entry.pc;
    assign halted     = (state_reg == S_HALT);

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch requester that drives the instruction memory read port and feeds decode.
- Holds the PC and issues one combinational-read fetch per cycle.
- Buffers fetched {pc, inst} pairs in a small circular queue.
- Presents queued entries to the IF/ID stage with a valid/ready handshake.
- Handles control-flow redirects (queue flush plus PC reload) and a halt request.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
QDEPTH, 2, instruction queue entries; power of two, at least 2.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
imem_rd_en  output  1  instruction memory read enable.
imem_addr  output  32  byte address to instruction memory; always word aligned.
imem_inst  input  32  instruction word returned combinationally in the same cycle.
redirect_valid  input  1  branch/jump/trap redirect from execute.
redirect_pc  input  32  redirect target.
halt_req  input  1  stop fetching; level-sensitive, sampled in S_RUN.
id_valid  output  1  queue head holds a valid entry.
id_ready  input  1  decode accepts the head entry.
id_inst  output  32  head instruction.
id_pc  output  32  PC of the head instruction.
halted  output  1  high while in S_HALT.

Behaviour:
Reset (async, rst_n=0):
- pc=RESET_PC; queue head, tail and count = 0; state = S_BOOT.
- All outputs 0: imem_rd_en=0, imem_addr=0, id_valid=0, id_inst=0, id_pc=0, halted=0.

FSM states: S_BOOT, S_RUN, S_HALT.
- S_BOOT: one idle cycle after reset deassert with no fetch; then -> S_RUN.
- S_RUN: if halt_req=1 and redirect_valid=0 -> S_HALT with no fetch in that cycle. Otherwise stay in S_RUN.
- S_HALT: halted=1, no fetches, queue keeps draining to decode. redirect_valid -> S_RUN; halt_req deassertion alone does not resume.

Fetch rule (combinational):
- fetch_fire = (state==S_RUN) & ~halt_req & ~redirect_valid & (count<QDEPTH).
- imem_rd_en = fetch_fire; imem_addr = fetch_fire ? pc : 0.
- On fetch_fire: write {pc, imem_inst} at tail, tail advances, pc <= pc+4. Wrap-around: 32'hFFFF_FFFC -> 0.

Dequeue:
- id_valid = (count!=0); id_inst and id_pc driven from the head entry, 0 when empty.
- pop = id_valid & id_ready & ~redirect_valid; head advances on pop.
- Full queue: no fetch in that cycle, even if a pop occurs (no full bypass). The fetch resumes the next cycle.
- Push and pop in the same cycle: count unchanged.
- Latency: fetch at cycle N appears on id_* at cycle N+1 when the queue was empty. Sustained throughput is 1 instruction/cycle while id_ready=1.

Redirect (priority over everything except reset):
- Flush: head, tail and count <= 0.
- pc <= {redirect_pc[31:2], 2'b00}.
- No fetch and no pop in that cycle; id_valid may be high but the handshake is void.
- In S_BOOT, a redirect loads the PC but still takes S_BOOT -> S_RUN.

Misc:
- Pointers wrap modulo QDEPTH; count is $clog2(QDEPTH)+1 bits.
- Reset mid-operation discards all queued entries.

Decomposition:
- Package fetch_pkg holds:
  - fetch_state_t enum {S_BOOT, S_RUN, S_HALT}.
  - fetch_entry_t packed struct {logic[31:0] pc; logic[31:0] inst;}.
  - Constant INST_BYTES=4.
- One sub-module is natural: fetch_queue, a parameterised circular buffer of fetch_entry_t.
  - Inputs: push, pop, flush.
  - Outputs: head entry, count, full, empty.
- fetch_unit holds the PC, the FSM and the fetch/redirect logic.

Test Plan:
- Reset and boot: rst_n low 3 cycles then high, id_ready=1, imem_inst=addr-tagged pattern -> imem_rd_en=0 in the first cycle after deassert. Fetches at 0x0, 0x4, 0x8 on consecutive cycles; id_pc 0x0, 0x4, 0x8 one cycle later with matching id_inst.
- Backpressure: id_ready=0 from cycle 2 -> exactly QDEPTH=2 entries fetched (0x0, 0x4), then imem_rd_en=0. id_pc held at 0x0. Releasing id_ready gives id_pc 0x0, 0x4, 0x8 with no duplicates or losses.
- Redirect with a full queue: redirect_pc=0x0000_0102 -> next cycle id_valid=0 and pc=0x100. The following cycle fetches 0x100; the old entries are never presented.
- Halt/resume: halt_req=1 with 2 queued entries -> halted=1 the next cycle, no fetches, both entries drain. redirect_valid with redirect_pc=0x40 -> S_RUN and a fetch at 0x40.
- Wrap-around: redirect to 0xFFFF_FFF8 -> fetches at 0xFFFF_FFF8, 0xFFFF_FFFC, then 0x0000_0000.
- Async reset mid-stream: rst_n pulsed low between clock edges with the queue non-empty -> id_valid=0, imem_rd_en=0 and halted=0 immediately. After release the fetch restarts at RESET_PC.
